// File: rtl/fp_mul_pkg.sv
// Shared constants for the FP multiplier issue controller: FSM encoding and special FP words.
package fp_mul_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  localparam logic [31:0]   FP_QNAN        = 32'h7FFFFFFF;
  localparam int unsigned   FP_MUL_MAX_LAT = 14;
  localparam logic [30:0]   FP_INF_MASK    = 31'h7F800000;

endpackage

// File: rtl/fp_op_fifo.sv
// Synchronous operand FIFO with registered occupancy count; no read bypass.
module fp_op_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 68
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fp_mul_issue_ctrl.sv
// Operand feeder / result collector for the FP multiplier core.
// Optional watchdog on the WAIT state when MUL_WDOG_EN is defined.
module fp_mul_issue_ctrl
  import fp_mul_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_op1,
  input  logic [31:0]      in_op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             mul_start,
  output logic [31:0]      mul_op1,
  output logic [31:0]      mul_op2,
  input  logic [31:0]      mul_res,
  input  logic             mul_done,
`ifdef MUL_WDOG_EN
  output logic             out_err,
`endif
  output logic             busy
);

  if (TIMEOUT <= FP_MUL_MAX_LAT) begin : g_bad_timeout
    $error("TIMEOUT must exceed the multiplier core latency");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two, at least 2");
  end

  localparam int unsigned FW = 64 + TAG_W;

  logic [1:0]       state_q, state_d;
  logic [31:0]      op1_q, op1_d, op2_q, op2_d;
  logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_res_q, out_res_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0] fifo_rdata;

`ifdef MUL_WDOG_EN
  localparam int unsigned CntW       = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  assign out_err = err_q;
`endif

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;

  fp_op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({in_tag, in_op1, in_op2}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    cur_tag_d   = cur_tag_q;
    out_res_d   = out_res_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q && !out_ready;
    fifo_pop    = 1'b0;
`ifdef MUL_WDOG_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    case (state_q)
      StIdle: begin
        // Only issue when the result slot will be free by the time this op completes.
        if (!fifo_empty && (!out_valid_q || out_ready)) begin
          fifo_pop                    = 1'b1;
          {cur_tag_d, op1_d, op2_d}   = fifo_rdata;
          state_d                     = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef MUL_WDOG_EN
        cnt_d = '0;
`endif
      end
      StWait: begin
        if (mul_done) begin
          out_res_d   = mul_res;
          out_tag_d   = cur_tag_q;
          out_valid_d = 1'b1;
          state_d     = StIdle;
`ifdef MUL_WDOG_EN
          err_d = 1'b0;
        end else if (cnt_q == CntMax) begin
          out_res_d   = FP_QNAN;
          out_tag_d   = cur_tag_q;
          out_valid_d = 1'b1;
          err_d       = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      op1_q       <= '0;
      op2_q       <= '0;
      cur_tag_q   <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_tag_q   <= '0;
`ifdef MUL_WDOG_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      cur_tag_q   <= cur_tag_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_tag_q   <= out_tag_d;
`ifdef MUL_WDOG_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end

  assign mul_start = (state_q == StIssue);
  assign mul_op1   = op1_q;
  assign mul_op2   = op2_q;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_tag   = out_tag_q;
  assign busy      = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_fp_mul_issue_ctrl.sv
// Self-checking bench for fp_mul_issue_ctrl with a behavioural multiplier stub and scoreboard.
// Define MUL_WDOG_EN to also exercise the watchdog path.
module tb_fp_mul_issue_ctrl;

  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_op1 = '0, in_op2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_res;
  logic [TAG_W-1:0] out_tag;
  logic             mul_start;
  logic [31:0]      mul_op1, mul_op2;
  logic [31:0]      mul_res;
  logic             mul_done;
  logic             busy;
`ifdef MUL_WDOG_EN
  logic             out_err;
`endif

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int out_cnt = 0;
  int core_lat = 3;
  bit core_hang = 1'b0;
  bit inj_done = 1'b0;
  logic [31:0] inj_val = '0;

  logic [31:0]      exp_res[$];
  logic [TAG_W-1:0] exp_tag[$];
  logic [31:0]      exp_op1[$];
  logic [31:0]      exp_op2[$];

  always #5 clk = ~clk;

  fp_mul_issue_ctrl #(
    .DEPTH   (4),
    .TAG_W   (TAG_W),
    .TIMEOUT (31)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op1    (in_op1),
    .in_op2    (in_op2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag),
    .mul_start (mul_start),
    .mul_op1   (mul_op1),
    .mul_op2   (mul_op2),
    .mul_res   (mul_res),
    .mul_done  (mul_done),
`ifdef MUL_WDOG_EN
    .out_err   (out_err),
`endif
    .busy      (busy)
  );

  // Reference single-precision products for the vectors this bench uses.
  function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40100000;
    if (a == 32'h7F800000 && b == 32'h00000000) return 32'h7FFFFFFF;
    if (a == 32'h3F800000) return b;
    return a ^ b;
  endfunction

  // Multiplier core stub: checks issued operands, holds them, answers after core_lat cycles.
  initial begin : core_stub
    logic [31:0] o1, o2;
    bit aborted;
    mul_done = 1'b0;
    mul_res  = '0;
    forever begin
      @(negedge clk);
      if (inj_done) begin
        inj_done = 1'b0;
        mul_res  = inj_val;
        mul_done = 1'b1;
        @(negedge clk);
        mul_done = 1'b0;
      end else if (mul_start && !rst) begin
        start_cnt++;
        o1 = mul_op1;
        o2 = mul_op2;
        checks++;
        if (exp_op1.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected: got op1=%h op2=%h, required no issue", o1, o2);
        end else begin
          if (o1 !== exp_op1[0] || o2 !== exp_op2[0]) begin
            errors++;
            $display("FAIL issue_operands: got %h*%h, required %h*%h", o1, o2, exp_op1[0],
                     exp_op2[0]);
          end
          void'(exp_op1.pop_front());
          void'(exp_op2.pop_front());
        end
        if (!core_hang) begin
          aborted = 1'b0;
          for (int i = 0; i < core_lat && !aborted; i++) begin
            @(posedge clk);
            #1;
            if (rst) aborted = 1'b1;
            else if (mul_start) begin
              errors++;
              $display("FAIL start_pulse: got mul_start=1 during WAIT, required 0");
            end
          end
          if (!aborted) begin
            checks++;
            if (mul_op1 !== o1 || mul_op2 !== o2) begin
              errors++;
              $display("FAIL operand_hold: got %h*%h, required %h*%h", mul_op1, mul_op2, o1, o2);
            end
            mul_res  = fp_ref(o1, o2);
            mul_done = 1'b1;
            @(posedge clk);
            #1;
            mul_done = 1'b0;
          end
        end
      end
    end
  end

  // Output scoreboard: compare every accepted result in order.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      out_cnt++;
      checks++;
      if (exp_res.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got res=%h tag=%h, required no output", out_res, out_tag);
      end else begin
        if (out_res !== exp_res[0] || out_tag !== exp_tag[0]) begin
          errors++;
          $display("FAIL out_order: got res=%h tag=%h, required res=%h tag=%h", out_res, out_tag,
                   exp_res[0], exp_tag[0]);
        end
        void'(exp_res.pop_front());
        void'(exp_tag.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    bit acc = 1'b0;
    exp_op1.push_back(a);
    exp_op2.push_back(b);
    exp_res.push_back(fp_ref(a, b));
    exp_tag.push_back(t);
    in_valid = 1'b1;
    in_op1   = a;
    in_op2   = b;
    in_tag   = t;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) begin
      errors++;
      checks++;
      $display("FAIL push_timeout: got in_ready=0 for 200 cycles, required acceptance");
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      tick();
      ok = out_valid;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      tick();
      ok = (exp_res.size() == 0) && !busy && !out_valid;
    end
  endtask

  task automatic test_reset();
    #1;
    checks += 8;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (mul_start !== 1'b0) begin errors++; $display("FAIL rst_mul_start: got %b, required 0", mul_start); end
    if (mul_op1 !== 32'h0 || mul_op2 !== 32'h0) begin
      errors++; $display("FAIL rst_mul_ops: got %h %h, required 0 0", mul_op1, mul_op2);
    end
    if (out_res !== 32'h0)  begin errors++; $display("FAIL rst_out_res: got %h, required 0", out_res); end
    if (out_tag !== '0)     begin errors++; $display("FAIL rst_out_tag: got %h, required 0", out_tag); end
`ifdef MUL_WDOG_EN
    if (out_err !== 1'b0)   begin errors++; $display("FAIL rst_out_err: got %b, required 0", out_err); end
`else
    if (dut.state_q !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d, required 0", dut.state_q); end
`endif
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    int s0 = start_cnt;
    out_ready = 1'b0;
    push(32'h40000000, 32'h40400000, 4'd3);
    wait_valid(ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL single_valid: got out_valid=0, required 1"); end
    if (out_res !== 32'h40C00000) begin errors++; $display("FAIL single_res: got %h, required 40c00000", out_res); end
    if (out_tag !== 4'd3) begin errors++; $display("FAIL single_tag: got %h, required 3", out_tag); end
    if (start_cnt != s0 + 1) begin errors++; $display("FAIL single_starts: got %0d, required 1", start_cnt - s0); end
    repeat (5) tick();
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL single_hold_valid: got %b, required 1", out_valid); end
    if (out_res !== 32'h40C00000) begin errors++; $display("FAIL single_hold_res: got %h, required 40c00000", out_res); end
    out_ready = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_drain: got busy=%b valid=%b, required idle", busy, out_valid); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int o0 = out_cnt;
    out_ready = 1'b1;
    push(32'h3FC00000, 32'h3FC00000, 4'd7);
    push(32'h7F800000, 32'h00000000, 4'd8);
    wait_idle(ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL b2b_drain: got busy=%b, required idle", busy); end
    if (out_cnt != o0 + 2) begin errors++; $display("FAIL b2b_count: got %0d, required 2", out_cnt - o0); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int o0 = out_cnt;
    int s0 = start_cnt;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h3F800000, 32'h40000000 + 32'(i), 4'(i + 1));
    wait_valid(ok);
    repeat (2) tick();
    checks += 4;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got in_ready=%b, required 0", in_ready); end
    if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b, required 1", busy); end
    if (out_res !== 32'h40000000) begin errors++; $display("FAIL bp_first: got %h, required 40000000", out_res); end
    if (start_cnt != s0 + 1) begin errors++; $display("FAIL bp_starts: got %0d, required 1", start_cnt - s0); end
    out_ready = 1'b1;
    push(32'h3F800000, 32'h40A00000, 4'd6);
    wait_idle(ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL bp_drain: got busy=%b, required idle", busy); end
    if (out_cnt != o0 + 6) begin errors++; $display("FAIL bp_count: got %0d, required 6", out_cnt - o0); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int o0;
    out_ready = 1'b1;
    core_lat  = 20;
    for (int i = 0; i < 5; i++) push(32'h3F800000, 32'h40800000 + 32'(i), 4'(i + 9));
    tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_pre_full: got in_ready=%b, required 0", in_ready); end
    #2;
    rst = 1'b1;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b, required 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b, required 1", in_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b, required 0", busy); end
    if (mul_op1 !== 32'h0 || mul_start !== 1'b0) begin
      errors++; $display("FAIL mid_mul: got op1=%h start=%b, required 0 0", mul_op1, mul_start);
    end
    exp_res.delete();
    exp_tag.delete();
    exp_op1.delete();
    exp_op2.delete();
    repeat (3) tick();
    rst = 1'b0;
    core_lat = 3;
    tick();
    o0 = out_cnt;
    push(32'h3FC00000, 32'h3FC00000, 4'd2);
    wait_idle(ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL mid_recover: got busy=%b, required idle", busy); end
    if (out_cnt != o0 + 1) begin errors++; $display("FAIL mid_count: got %0d, required 1", out_cnt - o0); end
  endtask

  task automatic test_spurious_done();
    bit ok;
    int s0 = start_cnt;
    inj_val  = 32'hDEADBEEF;
    inj_done = 1'b1;
    repeat (4) tick();
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL spur_idle_valid: got %b, required 0", out_valid); end
    if (out_res === 32'hDEADBEEF) begin errors++; $display("FAIL spur_idle_res: got %h, required not deadbeef", out_res); end
    if (start_cnt != s0) begin errors++; $display("FAIL spur_idle_start: got %0d, required 0", start_cnt - s0); end
    out_ready = 1'b0;
    push(32'h3F800000, 32'h41200000, 4'd5);
    wait_valid(ok);
    inj_done = 1'b1;
    repeat (4) tick();
    checks += 2;
    if (out_res !== 32'h41200000) begin errors++; $display("FAIL spur_held_res: got %h, required 41200000", out_res); end
    if (out_tag !== 4'd5) begin errors++; $display("FAIL spur_held_tag: got %h, required 5", out_tag); end
    out_ready = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL spur_drain: got busy=%b, required idle", busy); end
  endtask

`ifdef MUL_WDOG_EN
  task automatic test_watchdog();
    bit ok = 1'b0;
    int cyc = 0;
    out_ready = 1'b0;
    core_hang = 1'b1;
    push(32'h3F800000, 32'h40400000, 4'd9);
    exp_res[exp_res.size() - 1] = 32'h7FFFFFFF;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = mul_start;
    end
    ok = 1'b0;
    while (!ok && cyc < 100) begin
      @(negedge clk);
      cyc++;
      ok = out_valid;
    end
    #1;
    checks += 4;
    if (cyc != 32) begin errors++; $display("FAIL wdog_cycles: got %0d, required 32", cyc); end
    if (out_res !== 32'h7FFFFFFF) begin errors++; $display("FAIL wdog_res: got %h, required 7fffffff", out_res); end
    if (out_err !== 1'b1) begin errors++; $display("FAIL wdog_err: got %b, required 1", out_err); end
    if (dut.state_q !== 2'd0) begin errors++; $display("FAIL wdog_state: got %0d, required 0", dut.state_q); end
    core_hang = 1'b0;
    out_ready = 1'b1;
    push(32'h3F800000, 32'h40E00000, 4'd1);
    wait_idle(ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL wdog_drain: got busy=%b, required idle", busy); end
    if (out_err !== 1'b0) begin errors++; $display("FAIL wdog_clear: got %b, required 0", out_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_spurious_done();
`ifdef MUL_WDOG_EN
    test_watchdog();
`endif
    checks++;
    if (exp_res.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d expected results pending, required 0", exp_res.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
